// File: rtl/pe_pram_controller.sv
// Palette RAM responder: 256x32 palette shared between the priority
// evaluator (one-cycle lookups) and a stalled CPU pulse/ack port.
module pe_pram_controller (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        gfx_busy,
  input  logic [31:0] gfx_address,
  input  logic        gfx_is_obj,
  output logic [31:0] gfx_data,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_size,
  input  logic [9:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic        r_write;
  logic [1:0]  r_size;
  logic [9:0]  r_addr;
  logic [31:0] r_wdata;

  logic [31:0] mem [256];

  logic        latch;
  logic        cpu_access;
  logic [7:0]  bsel;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [7:0]  gfx_idx;
  logic [7:0]  cpu_idx;

  logic unused_gfx_bits;
  assign unused_gfx_bits = ^{gfx_address[31:9], gfx_address[1:0]};

  assign gfx_idx = {gfx_is_obj, gfx_address[8:2]};
  assign cpu_idx = r_addr[9:2];

  always_comb begin
    state_nxt  = state;
    latch      = 1'b0;
    cpu_access = 1'b0;
    cpu_ready  = 1'b0;
    cpu_ack    = 1'b0;
    unique case (state)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req) begin
          latch     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!gfx_busy) begin
          cpu_access = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        cpu_ack   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bsel = r_wdata[7:0];
    unique case (r_addr[1:0])
      2'd0: bsel = r_wdata[7:0];
      2'd1: bsel = r_wdata[15:8];
      2'd2: bsel = r_wdata[23:16];
      2'd3: bsel = r_wdata[31:24];
      default: bsel = r_wdata[7:0];
    endcase
  end

  // Byte stores replicate into both lanes of the addressed halfword.
  always_comb begin
    be = 4'b0000;
    wd = r_wdata;
    unique case (r_size)
      2'd0: begin
        wd = {4{bsel}};
        be = r_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'd1: be = r_addr[1] ? 4'b1100 : 4'b0011;
      2'd2: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!(cpu_access && r_write))
      be = 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      r_write <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 10'd0;
      r_wdata <= 32'd0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        r_write <= cpu_write;
        r_size  <= cpu_size;
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (be[i])
        mem[cpu_idx][8*i +: 8] <= wd[8*i +: 8];
  end

  // cpu_access implies !gfx_busy, so the two reads never share a cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      gfx_data  <= 32'd0;
      cpu_rdata <= 32'd0;
    end else begin
      if (gfx_busy)
        gfx_data <= mem[gfx_idx];
      if (cpu_access && !r_write)
        cpu_rdata <= mem[cpu_idx];
    end
  end

endmodule

// File: tb/tb_pe_pram_controller.sv
// Directed bench for pe_pram_controller: vector table plus
// hand sequences for gfx lookups, stray requests and reset.
module tb_pe_pram_controller;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        gfx_busy;
  logic [31:0] gfx_address;
  logic        gfx_is_obj;
  logic [31:0] gfx_data;
  logic        cpu_req;
  logic        cpu_write;
  logic [1:0]  cpu_size;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pe_pram_controller dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .gfx_busy   (gfx_busy),
    .gfx_address(gfx_address),
    .gfx_is_obj (gfx_is_obj),
    .gfx_data   (gfx_data),
    .cpu_req    (cpu_req),
    .cpu_write  (cpu_write),
    .cpu_size   (cpu_size),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata)
  );

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
    int          busy;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cpu_op(input bit w, input logic [1:0] sz,
                        input logic [9:0] a, input logic [31:0] d,
                        input int busy_until,
                        output logic [31:0] rd, output int lat,
                        output int early);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_write = w;
    cpu_size  = sz;
    cpu_addr  = a;
    cpu_wdata = d;
    if (busy_until > 0) gfx_busy = 1'b1;
    lat   = 0;
    early = 0;
    forever begin
      @(negedge clk);
      cpu_req = 1'b0;
      lat++;
      if (busy_until > 0 && lat == busy_until) gfx_busy = 1'b0;
      if (cpu_ack) break;
      if (lat >= 50) break;
    end
    if (busy_until > 0 && lat < busy_until + 1) early = 1;
    rd = cpu_rdata;
  endtask

  task automatic do_read(input string name, input logic [9:0] a,
                         input logic [31:0] exp);
    logic [31:0] rd;
    int lat, early;
    cpu_op(1'b0, 2'd2, a, 32'h0, 0, rd, lat, early);
    chk({name, "_rdata"}, rd, exp);
  endtask

  task automatic do_write(input logic [1:0] sz, input logic [9:0] a,
                          input logic [31:0] d);
    logic [31:0] rd;
    int lat, early;
    cpu_op(1'b1, sz, a, d, 0, rd, lat, early);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] last_rd;
    int lat, early, acks;

    rst_b       = 1'b0;
    gfx_busy    = 1'b0;
    gfx_address = 32'h0;
    gfx_is_obj  = 1'b0;
    cpu_req     = 1'b0;
    cpu_write   = 1'b0;
    cpu_size    = 2'd0;
    cpu_addr    = 10'd0;
    cpu_wdata   = 32'd0;

    vecs.push_back('{1'b1, 2'd2, 10'h004, 32'h7FFF001F, 32'h0, 0, 2});
    vecs.push_back('{1'b0, 2'd2, 10'h004, 32'h0, 32'h7FFF001F, 0, 2});
    vecs.push_back('{1'b1, 2'd2, 10'h004, 32'h12345678, 32'h0, 0, 2});
    vecs.push_back('{1'b1, 2'd0, 10'h007, 32'hAB000000, 32'h0, 0, 2});
    vecs.push_back('{1'b0, 2'd2, 10'h004, 32'h0, 32'hABAB5678, 0, 2});
    vecs.push_back('{1'b1, 2'd1, 10'h005, 32'h000000CC, 32'h0, 0, 2});
    vecs.push_back('{1'b0, 2'd0, 10'h006, 32'h0, 32'hABAB00CC, 0, 2});
    vecs.push_back('{1'b1, 2'd2, 10'h208, 32'h000003E0, 32'h0, 0, 2});
    vecs.push_back('{1'b1, 2'd3, 10'h004, 32'hFFFFFFFF, 32'h0, 0, 2});
    vecs.push_back('{1'b0, 2'd2, 10'h004, 32'h0, 32'hABAB00CC, 0, 2});
    vecs.push_back('{1'b1, 2'd2, 10'h000, 32'h11223344, 32'h0, 0, 2});
    vecs.push_back('{1'b1, 2'd0, 10'h001, 32'h00009900, 32'h0, 0, 2});
    vecs.push_back('{1'b0, 2'd2, 10'h000, 32'h0, 32'h11229999, 0, 2});
    vecs.push_back('{1'b1, 2'd2, 10'h008, 32'hCAFEF00D, 32'h0, 0, 2});
    vecs.push_back('{1'b1, 2'd1, 10'h00B, 32'hBEEF0000, 32'h0, 0, 2});
    vecs.push_back('{1'b0, 2'd1, 10'h008, 32'h0, 32'hBEEFF00D, 0, 2});
    vecs.push_back('{1'b1, 2'd2, 10'h00C, 32'h0, 32'h0, 0, 2});
    vecs.push_back('{1'b1, 2'd2, 10'h00C, 32'hDEADBEEF, 32'h0, 6, 7});
    vecs.push_back('{1'b0, 2'd2, 10'h00C, 32'h0, 32'hDEADBEEF, 0, 2});

    #12;
    chk("rst_gfx_data", gfx_data, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd1);
    @(negedge clk);
    rst_b = 1'b1;

    // gfx lookups during the stalled vector target word 130
    gfx_is_obj  = 1'b1;
    gfx_address = 32'h008;
    last_rd     = 32'h0;
    foreach (vecs[i]) begin
      cpu_op(vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd,
             vecs[i].busy, rd, lat, early);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_rdata_held", i), rd, last_rd);
      end else begin
        chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp);
        last_rd = vecs[i].exp;
      end
      chk($sformatf("v%0d_ack_ready", i), {31'd0, cpu_ready}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_ready_back", i), {31'd0, cpu_ready}, 32'd1);
      chk($sformatf("v%0d_ack_once", i), {31'd0, cpu_ack}, 32'd0);
    end
    chk("stall_gfx_data", gfx_data, 32'h000003E0);

    // gfx lookup and hold
    @(negedge clk);
    gfx_busy    = 1'b1;
    gfx_is_obj  = 1'b1;
    gfx_address = 32'h008;
    @(negedge clk);
    chk("gfx_obj130", gfx_data, 32'h000003E0);
    gfx_is_obj  = 1'b0;
    gfx_address = 32'h004;
    @(negedge clk);
    chk("gfx_bg1", gfx_data, 32'hABAB00CC);
    gfx_busy    = 1'b0;
    gfx_address = 32'h00C;
    @(negedge clk);
    chk("gfx_hold1", gfx_data, 32'hABAB00CC);
    @(negedge clk);
    chk("gfx_hold2", gfx_data, 32'hABAB00CC);

    // stray request while in WAIT
    do_write(2'd2, 10'h014, 32'h55555555);
    do_write(2'd2, 10'h010, 32'h00000000);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_write = 1'b1;
    cpu_size  = 2'd2;
    cpu_addr  = 10'h010;
    cpu_wdata = 32'h01010101;
    @(negedge clk);
    cpu_addr  = 10'h014;
    cpu_wdata = 32'h02020202;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (cpu_ack) acks++;
    end
    chk("stray_ack_count", acks, 1);
    do_read("stray_w10", 10'h010, 32'h01010101);
    do_read("stray_w14", 10'h014, 32'h55555555);

    // reset while a write is stalled in WAIT
    do_write(2'd2, 10'h018, 32'h600DF00D);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_write = 1'b1;
    cpu_size  = 2'd2;
    cpu_addr  = 10'h018;
    cpu_wdata = 32'hBADBAD00;
    gfx_busy  = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_ready", {31'd0, cpu_ready}, 32'd0);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, cpu_ready}, 32'd1);
    chk("mid_rst_ack", {31'd0, cpu_ack}, 32'd0);
    @(negedge clk);
    rst_b    = 1'b1;
    gfx_busy = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    chk("post_rst_acks", acks, 0);
    do_read("post_rst_old", 10'h018, 32'h600DF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_pram_controller.md
# pe_pram_controller

Palette RAM responder for the priority evaluation stage. It holds the 1 KiB palette (256 × 32-bit words: BG palette in words 0–127, OBJ palette in words 128–255). It answers the priority evaluator's per-cycle colour lookups with one-cycle latency. CPU accesses are serviced through a pulse/ack handshake only while the graphics pipeline is not using the port.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- gfx_busy  in  1  high while the graphics FSM owns the palette port.
- gfx_address  in  32  byte address from the priority evaluator, equal to {palette index, 1'b0}; only bits [8:2] are used.
- gfx_is_obj  in  1  selects the OBJ half of palette RAM.
- gfx_data  out  32  palette word for the previous cycle's gfx lookup.
- cpu_req  in  1  single-cycle request pulse; honoured only when cpu_ready=1.
- cpu_write  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal; sampled with cpu_req.
- cpu_addr  in  10  byte address in palette RAM; sampled with cpu_req.
- cpu_wdata  in  32  write data, lane-aligned to the byte address (byte at [8·a+7:8·a], where a=cpu_addr[1:0]); sampled with cpu_req.
- cpu_ready  out  1  high in IDLE; the block can accept a request.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  full word at cpu_addr[9:2]; valid while cpu_ack=1; held afterwards.

## Operation
- Storage is a single-port array of 256 × 32 bits. It has per-byte write enables and synchronous read, and infers to BRAM. Reset does not clear its contents.
- Graphics path (active when gfx_busy=1):
  - Word index = {gfx_is_obj, gfx_address[8:2]}.
  - gfx_data <= mem[index] on every edge.
  - When gfx_busy=0, gfx_data holds its value.
  - The graphics path never writes.
- CPU FSM, states IDLE, WAIT, DONE:
  - IDLE: cpu_ready=1. When cpu_req=1, latch write/size/addr/wdata and go to WAIT.
  - WAIT: if gfx_busy=1, stay in WAIT with no memory access. If gfx_busy=0, perform the access this cycle and go to DONE.
  - DONE: cpu_ack=1, then go to IDLE.
  - cpu_req in WAIT or DONE is ignored: no queueing and no error.
- CPU write lane rules (w = cpu_addr[9:2], h = cpu_addr[1], b = selected byte of cpu_wdata):
  - Byte: write {b,b} into halfword h, with both bytes of that half enabled; the other half is unchanged.
  - Halfword: write cpu_wdata half h into half h; cpu_addr[0] is ignored.
  - Word: all four enables are set; cpu_addr[1:0] is ignored.
  - Size 3: no enables are set, but the handshake still completes with an ack.
- CPU read: cpu_rdata <= mem[w] at the end of the WAIT access cycle. It returns the whole word regardless of size. cpu_rdata is unchanged by writes.
- The port is used exclusively by one side: in any cycle, either the graphics read or the CPU access is performed, never both.

## Timing
- Reset values: gfx_data=0, cpu_rdata=0, cpu_ack=0, cpu_ready=1, FSM=IDLE. Latched request registers are cleared.
- Gfx latency is 1 cycle. An address presented in cycle N appears on gfx_data in cycle N+1, provided gfx_busy=1 in cycle N.
- CPU best case:
  - req in cycle N;
  - access in N+1;
  - ack and cpu_rdata valid in N+2;
  - cpu_ready=1 again in N+3.
- Each cycle with gfx_busy=1 during WAIT adds one cycle of latency. The stall is unbounded.
- Write visibility: a write performed in cycle M is visible to any read performed in cycle M+1 or later.
- gfx_busy rising in the same cycle the FSM enters WAIT: graphics wins and the CPU waits.
- gfx_busy falling: the CPU access occurs in that same cycle, provided the FSM is in WAIT.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and no ack is issued. If the memory write had not yet been performed, it is dropped and memory is unmodified.

## Test plan
- Word write, then read: gfx_busy=0; write size 2, addr 0x004, data 0x7FFF_001F; read addr 0x004 → ack at req+2, cpu_rdata=0x7FFF_001F.
- Byte duplication: preload word 1 with 0x1234_5678; byte write addr 0x007, wdata[31:24]=0xAB → word 1 = 0xABAB_5678. Then halfword write addr 0x005, wdata[15:0]=0x00CC → word 1 = 0xABAB_00CC.
- Gfx lookup: preload word 130 with 0x0000_03E0; gfx_busy=1, gfx_is_obj=1, gfx_address=0x008 → gfx_data=0x0000_03E0 one cycle later. Drop gfx_busy → gfx_data holds.
- Contention: CPU write issued while gfx_busy=1 for 5 cycles → no memory change and no ack during the stall. The write lands on the first cycle with gfx_busy=0; ack 1 cycle later; total req-to-ack latency = 7.
- Ignored and illegal requests: a cpu_req pulse in WAIT → exactly one ack and no second access. A size-3 write → ack with the memory word unchanged.
- Reset: assert rst_b=0 while in WAIT with a pending write → cpu_ready=1, cpu_ack=0, and a later read shows the old data.
